// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide, one bit per CALC cycle, with a registered result and zero flag.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             Zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b0111;
  localparam logic [3:0] OP_MULHU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_REMU  = 4'b1010;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res_c;
  logic             is_iter_c;
  logic             is_mul_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] mul_acc_c, mul_lo_c;
  logic [WIDTH:0]   div_trial_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_acc_c, div_lo_c;
  logic [WIDTH-1:0] iter_res_c;

  assign busy = busy_q;
  assign done = done_q;
  assign C    = c_q;
  assign Zero = zero_q;

  assign is_iter_c = (ALUOp >= OP_MUL) && (ALUOp <= OP_REMU);
  assign is_mul_c  = (op_q == OP_MUL) || (op_q == OP_MULHU);

  // Single-cycle datapath on the live inputs, used only at acceptance
  always_comb begin
    alu_res_c = A;
    case (ALUOp)
      OP_NOP:  alu_res_c = A;
      OP_ADD:  alu_res_c = A + B;
      OP_SUB:  alu_res_c = A - B;
      OP_AND:  alu_res_c = A & B;
      OP_OR:   alu_res_c = A | B;
      OP_SLT:  alu_res_c = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_res_c = WIDTH'(A < B);
      default: alu_res_c = A;
    endcase
  end

  // Shift-add step: acc:lo holds the running product, lo's LSB selects the add
  always_comb begin
    mul_sum_c = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    mul_acc_c = mul_sum_c[WIDTH:1];
    mul_lo_c  = {mul_sum_c[0], lo_q[WIDTH-1:1]};
  end

  // Restoring step: acc is the remainder, lo shifts dividend out and quotient in
  always_comb begin
    div_trial_c = {acc_q, lo_q[WIDTH-1]};
    div_ge_c    = div_trial_c >= {1'b0, opa_q};
    div_acc_c   = div_ge_c ? WIDTH'(div_trial_c - {1'b0, opa_q}) : div_trial_c[WIDTH-1:0];
    div_lo_c    = {lo_q[WIDTH-2:0], div_ge_c};
  end

  always_comb begin
    case (op_q)
      OP_MUL:   iter_res_c = mul_lo_c;
      OP_MULHU: iter_res_c = mul_acc_c;
      OP_DIVU:  iter_res_c = div_lo_c;
      default:  iter_res_c = div_acc_c;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    zero_d  = zero_q;
    op_d    = op_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = ALUOp;
          if (is_iter_c) begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = '0;
            if ((ALUOp == OP_MUL) || (ALUOp == OP_MULHU)) begin
              opa_d = A;
              lo_d  = B;
            end else begin
              opa_d = B;
              lo_d  = A;
            end
          end else begin
            state_d = S_DONE;
            c_d     = alu_res_c;
            zero_d  = (alu_res_c == '0);
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_mul_c) begin
          acc_d = mul_acc_c;
          lo_d  = mul_lo_c;
        end else begin
          acc_d = div_acc_c;
          lo_d  = div_lo_c;
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          c_d     = iter_res_c;
          zero_d  = (iter_res_c == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      zero_q  <= 1'b1;
      op_q    <= OP_NOP;
      opa_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: stimulus pushes expected results from an arithmetic
// reference model; a negedge monitor pops and checks on every done pulse.
module tb_alu_iter;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] acc;
    logic [3:0]  op;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    alu_op = 4'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, zero;
  logic [W-1:0]  c;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt = 0;
  int issued = 0;
  exp_t expq[$];

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(alu_op), .A(a), .B(b),
    .busy(busy), .done(done), .C(c), .Zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (op)
      4'd1:    return x + y;
      4'd2:    return x - y;
      4'd3:    return x & y;
      4'd4:    return x | y;
      4'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:    return (x < y) ? 32'd1 : 32'd0;
      4'd7:    return p[31:0];
      4'd8:    return p[63:32];
      4'd9:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd10:   return (y == 0) ? x : x % y;
      default: return x;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (op >= 4'd7 && op <= 4'd10) ? W + 1 : 1;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done: got done=1 with no outstanding request, required none (t=%0t)", $time);
      end else begin
        e = expq.pop_front();
        chk("result_C", 64'(c), 64'(e.c));
        chk("zero_flag", 64'(zero), 64'(e.c == 32'd0));
        chk("latency", 64'(cyc - int'(e.acc) + 1), 64'(lat_of(e.op)));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // Issue one request; caller is aligned just after a rising edge
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input bit inject);
    exp_t e;
    int k;
    int prev;
    alu_op = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    e.c    = ref_alu(op, av, bv);
    e.acc  = 32'(cyc + 1);
    e.op   = op;
    expq.push_back(e);
    issued++;
    prev = done_cnt;
    @(posedge clk); #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    alu_op = 4'($urandom);
    k = 0;
    while (done_cnt == prev && k < 100) begin
      @(negedge clk); #1;
      if (done_cnt == prev) chk("busy_while_calc", 64'(busy), 64'd1);
      if (inject && k == 5) begin
        start  = 1'b1;
        alu_op = 4'd1;
        a      = $urandom;
        b      = $urandom;
      end
      if (inject && k == 6) start = 1'b0;
      k++;
    end
    if (done_cnt == prev) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done in 100 cycles, required done for op %0d", op);
    end
    @(posedge clk); #1;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_C", 64'(c), 64'd0);
    chk("reset_Zero", 64'(zero), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    issue(4'd1, 32'hA0, 32'h0A, 1'b0);
    issue(4'd2, 32'hA0, 32'h0A, 1'b0);
    issue(4'd2, 32'hA0, 32'hA0, 1'b0);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(4'd7, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(4'd8, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(4'd9, 32'd100, 32'd7, 1'b0);
    issue(4'd10, 32'd100, 32'd7, 1'b0);
    issue(4'd9, 32'd5, 32'd0, 1'b0);
    issue(4'd10, 32'd5, 32'd0, 1'b0);
    issue(4'd0, 32'h1234_5678, 32'd9, 1'b0);
    issue(4'd13, 32'hCAFE_F00D, 32'd9, 1'b0);
    issue(4'd7, 32'hDEAD_BEEF, 32'h1234_5679, 1'b1);

    // Reset during CALC of a DIVU aborts it without a done pulse
    alu_op = 4'd9;
    a      = 32'hFFFF_0000;
    b      = 32'd3;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_C", 64'(c), 64'd0);
    chk("abort_Zero", 64'(zero), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    repeat (40) @(posedge clk);
    #1;

    // Randomized traffic, occasionally poking start while busy
    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits; legal values 8 to 64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: ALUOp  input  4  operation code, sampled with start.
REQ-006 Port: A, B  input  WIDTH each  operands, sampled with start.
REQ-007 Port: busy  output  1  high in any state other than IDLE.
REQ-008 Port: done  output  1  one-cycle pulse when C becomes valid.
REQ-009 Port: C  output  WIDTH  registered result.
REQ-010 Port: Zero  output  1  registered, equals (C == 0).

Function
REQ-011 Opcodes SHALL be:
- 0000 NOP (C = A)
- 0001 ADD
- 0010 SUB
- 0011 AND
- 0100 OR
- 0101 SLT (signed)
- 0110 SLTU
- 0111 MUL (low WIDTH bits of the unsigned product)
- 1000 MULHU (high WIDTH bits of the unsigned product)
- 1001 DIVU
- 1010 REMU
- 1011-1111 behave as NOP.
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 Transitions SHALL be:
- IDLE + start + single-cycle op (0000-0110, 1011-1111) -> DONE
- IDLE + start + iterative op (0111-1010) -> CALC
- CALC -> DONE after exactly WIDTH iteration cycles
- DONE -> IDLE unconditionally.
REQ-014 Single-cycle ops SHALL load C at the accepting edge; done is high in the following cycle (latency 1).
REQ-015 MUL/MULHU SHALL use shift-add with one product bit per CALC cycle; done is high WIDTH+1 cycles after the accepting edge.
REQ-016 DIVU/REMU SHALL use restoring division with one quotient bit per CALC cycle; latency is WIDTH+1, the same as multiply.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-018 SLT/SLTU SHALL produce 1 or 0 zero-extended to WIDTH.
REQ-019 Division by zero SHALL give DIVU = all ones and REMU = A, with unchanged latency.
REQ-020 A and B SHALL be captured internally at acceptance; input changes while busy SHALL NOT affect the result.
REQ-021 start while busy (CALC or DONE) SHALL be ignored with no queuing; start in IDLE the cycle after DONE SHALL be accepted.
REQ-022 C and Zero SHALL update only when a result is produced and SHALL hold their value through IDLE until the next result.
REQ-023 done SHALL be high for exactly one cycle per accepted start.
REQ-024 Intermediate iteration values SHALL NOT appear on C.

Reset
REQ-025 While rst is high, the block SHALL go to IDLE with busy=0, done=0, C=0 and Zero=1, regardless of clk.
REQ-026 rst asserted in CALC SHALL abort the operation; no done pulse follows.
REQ-027 After rst deasserts, start SHALL be accepted on the first rising edge.

Verification (WIDTH=32)
REQ-028 A=0xA0, B=0x0A, ADD -> C=0xAA, Zero=0, done one cycle after acceptance; SUB -> C=0x96; SUB with B=0xA0 -> C=0, Zero=1.
REQ-029 A=0xFFFFFFFF, B=1: SLT -> C=1; SLTU -> C=0; AND -> C=1; OR -> C=0xFFFFFFFF.
REQ-030 A=0x00010000, B=0x00010000: MUL -> C=0, Zero=1; MULHU -> C=1; done exactly 33 cycles after acceptance with busy high throughout.
REQ-031 A=100, B=7: DIVU -> C=14; REMU -> C=2. A=5, B=0: DIVU -> C=0xFFFFFFFF; REMU -> C=5; both with latency 33.
REQ-032 During a MUL, pulse start with ADD and change A/B -> ignored; the MUL result is unchanged and only one done pulse occurs.
REQ-033 rst pulse at CALC cycle 10 of a DIVU -> busy=0 and C=0 immediately, no done follows; a subsequent ADD 2+3 -> C=5.
